// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// Kernel geometry lives here so the datapath and sequencer agree.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        WRITE,
        DONE
    } state_e;

    localparam int KER_W     = 3;
    localparam int KER_H     = 3;
    localparam int CONV_TAPS = KER_W * KER_H;

endpackage

// File: rtl/conv_addr_gen.sv
// Window/tap walker for the convolution sequencer: row-major windows,
// row-major taps, address = (row+r)*IMG_W + (col+c).
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              tap_adv,
    input  logic              win_adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last_tap,
    output logic              last_win
);

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
    localparam logic [1:0]        TC_LAST  = 2'(KER_W - 1);
    localparam logic [1:0]        TR_LAST  = 2'(KER_H - 1);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [1:0]        tr_q, tr_d;
    logic [1:0]        tc_q, tc_d;
    logic [ADDR_W-1:0] y, x;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
            tr_q  <= '0;
            tc_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            tr_q  <= tr_d;
            tc_q  <= tc_d;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        tr_d  = tr_q;
        tc_d  = tc_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
            tr_d  = '0;
            tc_d  = '0;
        end else begin
            // tap position wraps to 0 after tap 8, ready for the next window
            if (tap_adv) begin
                if (tc_q == TC_LAST) begin
                    tc_d = '0;
                    tr_d = (tr_q == TR_LAST) ? 2'd0 : tr_q + 2'd1;
                end else begin
                    tc_d = tc_q + 2'd1;
                end
            end
            if (win_adv) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + ONE;
                end else begin
                    col_d = col_q + ONE;
                end
            end
        end
    end

    assign y        = row_q + ADDR_W'(tr_q);
    assign x        = col_q + ADDR_W'(tc_q);
    assign addr     = (y * W_A) + x;
    assign last_tap = (tr_q == TR_LAST) && (tc_q == TC_LAST);
    assign last_win = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/conv_layer_ctrl.sv
// Sequencer streaming every 3x3 window of the frame memory into the
// convolution datapath and writing each result to the output buffer.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int CONV_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] win_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              conv_valid,
    output logic [DATA_W-1:0] conv_data,
    input  logic [DATA_W-1:0] conv_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int LAT_W = $clog2(CONV_LAT + 1) + 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(CONV_LAT);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] win_cnt_q, win_cnt_d;
    logic              conv_valid_q, conv_valid_d;

    logic              clr, tap_adv, win_adv;
    logic              last_tap, last_win;
    logic [ADDR_W-1:0] gen_addr;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .tap_adv  (tap_adv),
        .win_adv  (win_adv),
        .addr     (gen_addr),
        .last_tap (last_tap),
        .last_win (last_win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            win_cnt_q    <= '0;
            conv_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            win_cnt_q    <= win_cnt_d;
            conv_valid_q <= conv_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        win_cnt_d = win_cnt_q;
        clr       = 1'b0;
        tap_adv   = 1'b0;
        win_adv   = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = LOAD;
                    clr       = 1'b1;
                    lat_d     = '0;
                    win_cnt_d = '0;
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                tap_adv = 1'b1;
                if (last_tap) begin
                    state_d = WAIT;
                    lat_d   = '0;
                end
            end
            WAIT: begin
                // first WAIT cycle carries the tap-8 beat into the datapath
                if (lat_q == LAT_LAST) begin
                    state_d = WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                win_cnt_d = win_cnt_q + ONE;
                if (last_win) begin
                    state_d = DONE;
                end else begin
                    win_adv = 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // a beat read in the abort cycle must not reach the datapath
    assign conv_valid_d = rd_en && !abort;

    assign busy       = (state_q != IDLE);
    assign win_cnt    = win_cnt_q;
    assign rd_addr    = rd_en ? gen_addr : '0;
    assign conv_valid = conv_valid_q;
    assign conv_data  = conv_valid_q ? rd_data : '0;
    assign wr_addr    = wr_en ? win_cnt_q : '0;
    assign wr_data    = wr_en ? conv_out : '0;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench: two sequencer instances (4x4/lat 2, 5x3/lat 0)
// driven by frame memories and a behavioural 3x3 datapath.
module tb_conv_layer_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- instance A: 4x4, CONV_LAT=2
    logic          a_start = 1'b0, a_abort = 1'b0;
    logic          a_busy, a_done, a_rd_en, a_conv_valid, a_wr_en;
    logic [AW-1:0] a_win_cnt, a_rd_addr, a_wr_addr;
    logic [DW-1:0] a_rd_data, a_conv_data, a_conv_out, a_wr_data;
    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] a_win [9];

    conv_layer_ctrl #(
        .IMG_W(4), .IMG_H(4), .DATA_W(DW), .ADDR_W(AW), .CONV_LAT(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .win_cnt(a_win_cnt),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .conv_valid(a_conv_valid), .conv_data(a_conv_data),
        .conv_out(a_conv_out),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    // ---------------- instance B: 5x3, CONV_LAT=0
    logic          b_start = 1'b0, b_abort = 1'b0;
    logic          b_busy, b_done, b_rd_en, b_conv_valid, b_wr_en;
    logic [AW-1:0] b_win_cnt, b_rd_addr, b_wr_addr;
    logic [DW-1:0] b_rd_data, b_conv_data, b_conv_out, b_wr_data;
    logic [DW-1:0] mem_b [64];
    logic [DW-1:0] b_win [9];

    conv_layer_ctrl #(
        .IMG_W(5), .IMG_H(3), .DATA_W(DW), .ADDR_W(AW), .CONV_LAT(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .win_cnt(b_win_cnt),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .conv_valid(b_conv_valid), .conv_data(b_conv_data),
        .conv_out(b_conv_out),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    // datapath: kernel columns [1,0,-1], oldest beat is tap 0
    function automatic logic [DW-1:0] win_sum(logic [DW-1:0] w [9]);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) s = s + w[i];
            else if (i % 3 == 2) s = s - w[i];
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr[5:0]];
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr[5:0]];
        if (a_conv_valid) begin
            for (int i = 0; i < 8; i++) a_win[i] <= a_win[i+1];
            a_win[8] <= a_conv_data;
        end
        if (b_conv_valid) begin
            for (int i = 0; i < 8; i++) b_win[i] <= b_win[i+1];
            b_win[8] <= b_conv_data;
        end
        a_conv_out <= win_sum(a_win);
    end

    always_comb b_conv_out = win_sum(b_win);

    // ---------------- recorded traffic of the last run (relative cycles)
    int            rd_q[$], rdc_q[$], cv_q[$], wc_q[$], dn_q[$];
    logic [DW-1:0] wa_q[$], wd_q[$];
    int            b_first, b_last;

    task automatic chk(string tag, longint obs, longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        rd_q.delete(); rdc_q.delete(); cv_q.delete();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); dn_q.delete();
        b_first = -1;
        b_last  = -1;
    endtask

    task automatic run_a(int cycles, int restart_at, int abort_at);
        clear_rec();
        for (int i = 0; i <= cycles; i++) begin
            @(negedge clk);
            if (a_rd_en) begin
                rd_q.push_back(int'(a_rd_addr));
                rdc_q.push_back(i);
            end
            if (a_conv_valid) cv_q.push_back(i);
            if (a_wr_en) begin
                wa_q.push_back(32'(a_wr_addr));
                wd_q.push_back(a_wr_data);
                wc_q.push_back(i);
            end
            if (a_done) dn_q.push_back(i);
            if (a_busy) begin
                if (b_first < 0) b_first = i;
                b_last = i;
            end
            a_start = (i == 0) || (i == restart_at);
            a_abort = (i == abort_at);
        end
        a_start = 1'b0;
        a_abort = 1'b0;
    endtask

    task automatic run_b(int cycles);
        clear_rec();
        for (int i = 0; i <= cycles; i++) begin
            @(negedge clk);
            if (b_rd_en) begin
                rd_q.push_back(int'(b_rd_addr));
                rdc_q.push_back(i);
            end
            if (b_wr_en) begin
                wa_q.push_back(32'(b_wr_addr));
                wd_q.push_back(b_wr_data);
                wc_q.push_back(i);
            end
            if (b_done) dn_q.push_back(i);
            if (b_busy) begin
                if (b_first < 0) b_first = i;
                b_last = i;
            end
            b_start = (i == 0);
        end
        b_start = 1'b0;
    endtask

    // reference: windows row-major, taps row-major, result from memory
    task automatic check_job(string tag, int w, int h, int lat,
                             logic [DW-1:0] m [64]);
        int            exp_rd[$], exp_rc[$], exp_wc[$];
        logic [DW-1:0] exp_wd[$];
        logic [DW-1:0] s;
        int            p, nw, k, a;
        p = 11 + lat;
        nw = (h - 2) * (w - 2);
        k = 0;
        for (int row = 0; row <= h - 3; row++) begin
            for (int col = 0; col <= w - 3; col++) begin
                s = '0;
                for (int t = 0; t < 9; t++) begin
                    a = (row + t / 3) * w + col + t % 3;
                    exp_rd.push_back(a);
                    exp_rc.push_back(1 + k * p + t);
                    if (t % 3 == 0) s = s + m[a];
                    else if (t % 3 == 2) s = s - m[a];
                end
                exp_wd.push_back(s);
                exp_wc.push_back((k + 1) * p);
                k++;
            end
        end
        chk({tag, " rd count"}, rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size(); i++) begin
            chk($sformatf("%s rd_addr[%0d]", tag, i),
                (i < rd_q.size()) ? rd_q[i] : -1, exp_rd[i]);
            chk($sformatf("%s rd_cyc[%0d]", tag, i),
                (i < rdc_q.size()) ? rdc_q[i] : -1, exp_rc[i]);
        end
        chk({tag, " wr count"}, wa_q.size(), nw);
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s wr_addr[%0d]", tag, i),
                (i < wa_q.size()) ? longint'(wa_q[i]) : -1, i);
            chk($sformatf("%s wr_data[%0d]", tag, i),
                (i < wd_q.size()) ? longint'(wd_q[i]) : -1,
                longint'(exp_wd[i]));
            chk($sformatf("%s wr_cyc[%0d]", tag, i),
                (i < wc_q.size()) ? wc_q[i] : -1, exp_wc[i]);
        end
        chk({tag, " done count"}, dn_q.size(), 1);
        chk({tag, " done cyc"},
            (dn_q.size() > 0) ? dn_q[0] : -1, 1 + nw * p);
        chk({tag, " busy rise"}, b_first, 1);
        chk({tag, " busy fall"}, b_last, 1 + nw * p);
    endtask

    task automatic chk_zero_a(string tag);
        chk({tag, " ctl bits"},
            {a_busy, a_done, a_rd_en, a_conv_valid, a_wr_en}, 0);
        chk({tag, " win_cnt"}, a_win_cnt, 0);
        chk({tag, " rd_addr"}, a_rd_addr, 0);
        chk({tag, " conv_data"}, a_conv_data, 0);
        chk({tag, " wr_addr"}, a_wr_addr, 0);
        chk({tag, " wr_data"}, a_wr_data, 0);
    endtask

    int win2[9] = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
    int late_rd, late_cv, t0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'(i);
            mem_b[i] = $urandom;
        end

        // reset state
        repeat (3) @(negedge clk);
        chk_zero_a("reset");
        chk("reset B ctl",
            {b_busy, b_done, b_rd_en, b_conv_valid, b_wr_en, b_win_cnt}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero_a("idle");

        // linear map, second start at cycle 10 must be ignored
        run_a(60, 10, -1);
        check_job("A lin", 4, 4, 2, mem_a);
        chk("A lin wr_data0 const",
            (wd_q.size() > 0) ? longint'(wd_q[0]) : -1, 32'hFFFF_FFFA);
        chk("A lin wr_data3 const",
            (wd_q.size() > 3) ? longint'(wd_q[3]) : -1, 32'hFFFF_FFFA);
        chk("A lin win_cnt hold", a_win_cnt, 4);
        chk("A lin idle busy", a_busy, 0);

        // random map
        for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
        run_a(60, -1, -1);
        check_job("A rnd", 4, 4, 2, mem_a);

        // abort at cycle 20, in the second window's LOAD
        run_a(30, -1, 20);
        late_rd = 0;
        late_cv = 0;
        foreach (rdc_q[i]) if (rdc_q[i] >= 21) late_rd++;
        foreach (cv_q[i]) if (cv_q[i] >= 21) late_cv++;
        chk("abort rd count", rd_q.size(), 16);
        chk("abort late rd_en", late_rd, 0);
        chk("abort late conv_valid", late_cv, 0);
        chk("abort wr count", wa_q.size(), 1);
        chk("abort no done", dn_q.size(), 0);
        chk("abort busy fall", b_last, 20);
        chk("abort win_cnt", a_win_cnt, 1);

        // abort together with start in IDLE: job must not start
        @(negedge clk);
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        chk("abort+start busy", a_busy, 0);
        chk("abort+start win_cnt", a_win_cnt, 1);
        @(negedge clk);
        chk("abort+start rd_en", a_rd_en, 0);

        // asynchronous reset in the drain cycle of window 1
        for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
        @(negedge clk);
        t0 = cyc;
        a_start = 1'b1;
        repeat (23) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        chk("pre-rst cycle", cyc - t0, 23);
        chk("pre-rst busy", a_busy, 1);
        chk("pre-rst conv_valid", a_conv_valid, 1);
        chk("pre-rst win_cnt", a_win_cnt, 1);
        #2 reset_n = 1'b0;
        #1 chk_zero_a("async rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_a(60, -1, -1);
        check_job("A post-rst", 4, 4, 2, mem_a);

        // 5x3 map, CONV_LAT=0
        run_b(40);
        check_job("B 5x3", 5, 3, 0, mem_b);
        for (int i = 0; i < 9; i++)
            chk($sformatf("B win2 rd[%0d]", i),
                (18 + i < rd_q.size()) ? rd_q[18+i] : -1, win2[i]);
        chk("B win_cnt hold", b_win_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Sequencer for the 3x3 convolution datapath: on `start`, walks every valid 3x3 window of an IMG_W x IMG_H feature map held in a frame memory. For each window it streams the 9 pixels into `convolution_layer` as 9 `valid` beats, waits out the datapath latency, and writes the sampled result to an output memory. It sits between the frame memory, the convolution datapath and the result buffer, and reports progress to the top-level AI core controller.

## Interface
Parameters:
- IMG_W, 8: map width in pixels, ≥3
- IMG_H, 8: map height in pixels, ≥3
- DATA_W, 32: pixel and result width
- ADDR_W, 16: memory address width, ≥ clog2(IMG_W*IMG_H)
- CONV_LAT, 2: cycles from the last window beat until `conv_out` holds that window's result

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start pulse, honoured only in IDLE
- abort  in  1  synchronous abort, return to IDLE
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after the last result write
- win_cnt  out  ADDR_W  windows completed in the current job
- rd_en  out  1  frame-memory read strobe
- rd_addr  out  ADDR_W  frame-memory address
- rd_data  in  DATA_W  read data, valid the cycle after rd_en
- conv_valid  out  1  to datapath `valid`
- conv_data  out  DATA_W  to datapath `data_in`
- conv_out  in  DATA_W  datapath result
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  result index, window order
- wr_data  out  DATA_W  result value

## Operation
- Reset values: all outputs 0. State is IDLE. Counters row, col, tap, lat and win_cnt are 0.
- Windows are visited in row-major order: row 0..IMG_H-3, col 0..IMG_W-3. Total windows NW = (IMG_H-2)*(IMG_W-2).
- Tap order: tap = 0..8, r = tap/3, c = tap%3. Read address = (row+r)*IMG_W + (col+c).
- States:
  - IDLE: `start` latches the job, clears the counters and goes to LOAD.
  - LOAD: issues one read per cycle with rd_en=1 for tap 0..8. After tap 8 it goes to WAIT.
  - WAIT: counts CONV_LAT+1 cycles; the first of these is the drain cycle for the tap-8 beat. Then goes to WRITE.
  - WRITE: drives wr_en=1, wr_addr=win_cnt, wr_data=conv_out. win_cnt increments. Then either advance col (wrap to 0 and increment row) and go to LOAD, or go to DONE after the last window.
  - DONE: pulses done for one cycle, then goes to IDLE.
- conv_valid and conv_data are rd_en and rd_data delayed one cycle. The 9 beats fully replace the datapath window, so no datapath clear is needed.
- busy = (state != IDLE). It rises the cycle after `start` and falls in the cycle after the `done` pulse.
- win_cnt holds its final value (NW) until the next `start`.
- `start` while busy is ignored.
- `abort` in any non-IDLE state goes to IDLE on the next edge:
  - rd_en, conv_valid and wr_en are 0 from that edge on.
  - No done pulse.
  - win_cnt keeps its partial value.
- `abort` and `start` asserted together in IDLE: abort wins and the job does not start.
- Reset asserted mid-job: all outputs return to 0 immediately (asynchronous). No done pulse.
- Arithmetic: addresses are unsigned ADDR_W bits. conv_out is passed through unmodified as a signed value.

## Timing
- Per window: 9 (LOAD) + CONV_LAT+1 (WAIT) + 1 (WRITE) = 11+CONV_LAT cycles, which is 13 at the default.
- Job: `start` at cycle 0 → first rd_en at cycle 1 → done at cycle 1 + NW*(11+CONV_LAT).
- The last wr_en is exactly one cycle before done.
- Reads are back-to-back within a window. There are no reads during WAIT, WRITE or DONE.

## Structure
- Shared package `conv_pkg`: state enum (IDLE, LOAD, WAIT, WRITE, DONE) and constant CONV_TAPS=9. The 3x3 kernel dimensions live here for reuse by the datapath.
- One natural sub-module: `conv_addr_gen`, holding the row/col/tap counters and the address multiply-add. It provides `last_tap` and `last_win` flags to the FSM.

## Test plan
- IMG_W=IMG_H=4, frame mem[a]=a, behavioural datapath with kernel columns [1,0,-1] and CONV_LAT=2 → 4 writes to wr_addr 0..3, each wr_data=-6 (0xFFFFFFFA). done at cycle 53, win_cnt=4.
- IMG_W=5, IMG_H=3 → rd_addr sequence for window 2 is 2,3,4,7,8,9,12,13,14. 3 writes, then done.
- `start` pulsed again at cycle 10 of a job → ignored; done timing unchanged.
- `abort` at cycle 20 of a 4x4 job → rd_en, conv_valid and wr_en are 0 from cycle 21. busy falls, no done, win_cnt=1.
- reset_n low mid-WAIT → all outputs 0 asynchronously. After release, a new start runs the full job correctly.
- CONV_LAT=0 → per-window period of 11 cycles, with wr_data sampled on the drain cycle plus one.
